// File: rtl/multi_cycle_shift_controller.sv
// Multi-cycle variable shifter: reaches any amount 0..N-1 using only a fixed
// "shift by STEP" stage and a fixed "shift by 1" stage, one stage per cycle.
module multi_cycle_shift_controller #(
  parameter int N    = 8,
  parameter int STEP = 3,
  parameter int AW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [AW-1:0] up_amount,
  input  logic          up_dir,
  input  logic          up_arith,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [N-1:0]  ONES   = '1;

  state_t        state;
  logic [N-1:0]  work;
  logic [AW-1:0] rem;
  logic          dir;
  logic          arith;
  logic          msb;

  logic [N-1:0]  stepped;
  logic [AW-1:0] rem_next;
  logic          fill;

  // Fixed-amount right shift; fill bits are ORed into the vacated top positions.
  function automatic logic [N-1:0] shr_fixed(input logic [N-1:0] v,
                                             input int unsigned s,
                                             input logic f);
    shr_fixed = (v >> s) | (f ? ~(ONES >> s) : '0);
  endfunction

  always_comb begin
    stepped  = work;
    rem_next = rem;
    fill     = dir & arith & msb;
    if (rem >= STEP_A) begin
      stepped  = dir ? shr_fixed(work, STEP, fill) : (work << STEP);
      rem_next = rem - STEP_A;
    end else if (rem != '0) begin
      stepped  = dir ? shr_fixed(work, 1, fill) : (work << 1);
      rem_next = rem - ONE_A;
    end
  end

  assign up_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      work       <= '0;
      rem        <= '0;
      dir        <= 1'b0;
      arith      <= 1'b0;
      msb        <= 1'b0;
      down_valid <= 1'b0;
      down_data  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (up_valid) begin
            work  <= up_data;
            rem   <= up_amount;
            dir   <= up_dir;
            arith <= up_arith;
            msb   <= up_data[N-1];
            busy  <= 1'b1;
            if (up_amount == '0) begin
              state      <= S_DONE;
              down_valid <= 1'b1;
              down_data  <= up_data;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work <= stepped;
          rem  <= rem_next;
          if (rem_next == '0) begin
            state      <= S_DONE;
            down_valid <= 1'b1;
            down_data  <= stepped;
          end
        end
        S_DONE: begin
          if (down_ready) begin
            state      <= S_IDLE;
            down_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          down_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_shift_controller.sv
// Directed-vector bench for multi_cycle_shift_controller (N=8, STEP=3).
module tb_multi_cycle_shift_controller;

  logic       clk;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic [2:0] up_amount;
  logic       up_dir;
  logic       up_arith;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] down_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  multi_cycle_shift_controller #(.N(8), .STEP(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amount  (up_amount),
    .up_dir     (up_dir),
    .up_arith   (up_arith),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    logic       arith;
    logic [7:0] exp;
    int         lat;
    int         hold;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE, measures latency (accept edge counts as 1),
  // holds off the consumer for 'hold' cycles, then releases it.
  task automatic do_req(input logic [7:0] d, input logic [2:0] a, input logic dr,
                        input logic ar, input logic [7:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    check("up_ready_before", int'(up_ready), 1);
    up_valid  = 1'b1;
    up_data   = d;
    up_amount = a;
    up_dir    = dr;
    up_arith  = ar;
    tick();
    up_valid = 1'b0;
    up_data  = ~d;
    up_dir   = ~dr;
    check("busy_after_accept", int'(busy), 1);
    lat = 1;
    while (!down_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", int'(down_data), int'(exp));
    for (int i = 0; i < hold; i++) begin
      up_valid = 1'b1;
      tick();
      check("hold_valid", int'(down_valid), 1);
      check("hold_data", int'(down_data), int'(exp));
      check("hold_up_ready", int'(up_ready), 0);
    end
    up_valid   = 1'b0;
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    check("release_valid", int'(down_valid), 0);
    check("release_up_ready", int'(up_ready), 1);
    check("release_busy", int'(busy), 0);
    check("release_data_held", int'(down_data), int'(exp));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] e;
    int k;

    vecs[0]  = '{8'hB6, 3'd5, 1'b0, 1'b0, 8'hC0, 4, 0};
    vecs[1]  = '{8'hB6, 3'd7, 1'b1, 1'b1, 8'hFF, 4, 0};
    vecs[2]  = '{8'hB6, 3'd7, 1'b1, 1'b0, 8'h01, 4, 0};
    vecs[3]  = '{8'h40, 3'd6, 1'b1, 1'b0, 8'h01, 3, 0};
    vecs[4]  = '{8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1, 0};
    vecs[5]  = '{8'h5A, 3'd0, 1'b1, 1'b1, 8'h5A, 1, 0};
    vecs[6]  = '{8'h81, 3'd1, 1'b0, 1'b0, 8'h02, 2, 5};
    vecs[7]  = '{8'h80, 3'd3, 1'b1, 1'b1, 8'hF0, 2, 0};
    vecs[8]  = '{8'h80, 3'd4, 1'b1, 1'b1, 8'hF8, 3, 1};
    vecs[9]  = '{8'hFF, 3'd7, 1'b0, 1'b0, 8'h80, 4, 0};
    vecs[10] = '{8'h0F, 3'd4, 1'b0, 1'b1, 8'hF0, 3, 0};
    vecs[11] = '{8'h7C, 3'd2, 1'b1, 1'b1, 8'h1F, 3, 2};

    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = 8'h00;
    up_amount  = 3'd0;
    up_dir     = 1'b0;
    up_arith   = 1'b0;
    down_ready = 1'b0;
    tick();
    tick();
    check("reset_down_valid", int'(down_valid), 0);
    check("reset_down_data", int'(down_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_up_ready", int'(up_ready), 0);
    rst = 1'b0;
    #1;
    check("post_reset_up_ready", int'(up_ready), 1);

    for (int i = 0; i < 12; i++)
      do_req(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].arith,
             vecs[i].exp, vecs[i].lat, vecs[i].hold);

    // Reset during the second SHIFT cycle of a long right shift.
    up_valid  = 1'b1;
    up_data   = 8'hFF;
    up_amount = 3'd7;
    up_dir    = 1'b1;
    up_arith  = 1'b0;
    tick();
    up_valid = 1'b0;
    check("midshift_busy1", int'(busy), 1);
    tick();
    check("midshift_busy2", int'(down_valid), 0);
    rst = 1'b1;
    tick();
    check("midrst_down_valid", int'(down_valid), 0);
    check("midrst_down_data", int'(down_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_up_ready", int'(up_ready), 0);
    rst = 1'b0;
    #1;
    do_req(8'h0F, 3'd4, 1'b0, 1'b0, 8'hF0, 3, 0);

    // Sweep of all amounts, directions and fill modes against the reference operators.
    for (int a = 0; a < 8; a++) begin
      for (int m = 0; m < 3; m++) begin
        d = 8'($urandom_range(0, 255));
        if (m == 0)      e = d << a;
        else if (m == 1) e = d >> a;
        else             e = $signed(d) >>> a;
        k = 1 + a / 3 + a % 3;
        do_req(d, 3'(a), m != 0, m == 2, e, k, int'($urandom_range(0, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
